// File: rtl/riscv_pkg.sv
// Shared RISC-V debug definitions: register-file geometry and dump FSM encoding.
package riscv_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_e;

endpackage : riscv_pkg

// File: rtl/reg_dump_unit.sv
// Streams every architectural register out as an (index, value) record while
// holding the core stalled; one read cycle plus one handshake cycle per record.
module reg_dump_unit
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_REGS   = riscv_pkg::NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  halt_req,
  output logic [REG_ADDR_W-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [REG_ADDR_W-1:0] dump_idx,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

  dump_state_e           state_q, state_d;
  logic [REG_ADDR_W-1:0] idx_q, idx_d;

  // Next-state and index sequencing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          idx_d   = '0;
        end
      end
      ST_READ: state_d = ST_SEND;
      ST_SEND: begin
        if (dump_valid && dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_READ;
            idx_d   = idx_q + REG_ADDR_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      busy       <= 1'b0;
      halt_req   <= 1'b0;
      dump_valid <= 1'b0;
      done       <= 1'b0;
      rf_raddr   <= '0;
      dump_idx   <= '0;
      dump_data  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy       <= (state_d != ST_IDLE);
      halt_req   <= (state_d != ST_IDLE);
      dump_valid <= (state_d == ST_SEND);
      done       <= (state_d == ST_DONE);
      rf_raddr   <= (state_d == ST_READ) ? idx_d : '0;
      // x0 is hardwired zero, whatever the read port returns
      if (state_q == ST_READ) begin
        dump_idx  <= idx_q;
        dump_data <= (idx_q == '0) ? '0 : rf_rdata;
      end
    end
  end

endmodule : reg_dump_unit

// File: tb/tb_reg_dump_unit.sv
// Randomized self-checking bench for reg_dump_unit against a record-list model.
module tb_reg_dump_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic [4:0]  rf_raddr;
  logic [63:0] rf_rdata;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [63:0] dump_data;
  logic        busy;
  logic        done;

  logic [63:0] rf_mem [32];
  int n_checks = 0;
  int n_pass   = 0;

  assign rf_rdata = rf_mem[rf_raddr];

  reg_dump_unit #(.DATA_WIDTH(64), .NUM_REGS(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .halt_req   (halt_req),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 64'(dump_valid), 64'd0);
    check({tag, "_busy"},  64'(busy),       64'd0);
    check({tag, "_halt"},  64'(halt_req),   64'd0);
    check({tag, "_done"},  64'(done),       64'd0);
    check({tag, "_raddr"}, 64'(rf_raddr),   64'd0);
  endtask

  task automatic preload_linear();
    for (int i = 0; i < 32; i++) rf_mem[i] = 64'h1000 + 64'(i);
  endtask

  // mode 0: ready high, 1: stall on record 5, 2: random ready,
  // 3: extra start pulses, 4: reset during record 20
  task automatic run_dump(input int mode);
    logic [63:0] exp_data [32];
    int  cyc, recs, hold, dones;
    bit  fin, extra_sent, was_reset;
    for (int i = 0; i < 32; i++) exp_data[i] = (i == 0) ? 64'd0 : rf_mem[i];
    recs = 0; hold = 0; dones = 0; fin = 0; extra_sent = 0; was_reset = 0;
    start      = 1'b1;
    dump_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!fin) begin
      start = 1'b0;
      check("busy_during_dump", 64'(busy), 64'd1);
      check("halt_during_dump", 64'(halt_req), 64'd1);
      if (mode == 4 && dump_valid && recs == 20) begin
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset");
        check("after_reset_idx",  64'(dump_idx), 64'd0);
        check("after_reset_data", dump_data,     64'd0);
        rst_n     = 1'b1;
        was_reset = 1;
        fin       = 1;
      end else begin
        case (mode)
          1: begin
            dump_ready = !(dump_valid && recs == 5 && hold < 10);
            if (!dump_ready) begin
              hold++;
              check("stall_idx",  64'(dump_idx), 64'd5);
              check("stall_data", dump_data,     64'h1005);
            end
          end
          2: dump_ready = 1'($urandom_range(0, 1));
          default: dump_ready = 1'b1;
        endcase
        if (mode == 3 && recs == 12 && !extra_sent) begin
          start      = 1'b1;
          extra_sent = 1;
        end
        if (dump_valid && dump_ready) begin
          if (mode == 0) check("record_cycle", 64'(cyc), 64'(2 + 2 * recs));
          if (recs < 32) begin
            check("record_idx",  64'(dump_idx), 64'(recs));
            check("record_data", dump_data,     exp_data[recs]);
          end else begin
            check("extra_record", 64'(recs), 64'd31);
          end
          recs++;
        end
        if (done) begin
          dones++;
          check("records_at_done", 64'(recs), 64'd32);
          if (mode == 0) check("done_cycle", 64'(cyc), 64'd65);
          if (mode == 3) start = 1'b1;
          fin = 1;
        end
        if (cyc > 2000) begin
          check("timeout", 64'(cyc), 64'd0);
          fin = 1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start      = 1'b0;
    dump_ready = 1'b0;
    if (!was_reset) begin
      check("done_count", 64'(dones), 64'd1);
      check_idle_outputs("post_done");
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("post_done_busy", 64'(busy), 64'd0);
        check("post_done_done", 64'(done), 64'd0);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    dump_ready = 1'b0;
    preload_linear();
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_idx",  64'(dump_idx), 64'd0);
    check("reset_data", dump_data,     64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_dump(0);
    run_dump(1);
    run_dump(3);

    for (int i = 0; i < 32; i++) rf_mem[i] = {$urandom, $urandom};
    rf_mem[0] = 64'hDEAD;
    run_dump(2);
    run_dump(2);

    preload_linear();
    rf_mem[0] = 64'hDEAD;
    run_dump(4);
    run_dump(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_reg_dump_unit
